// File: rtl/raw_debayer_2x2_if.sv
// Pixel-stream bundle around the 2x2 debayer: RAW Bayer in, RGB out.
// The upstream/bench side drives the i_* group and observes the o_* group.
interface raw_debayer_2x2_if;
   logic       i_vsync;
   logic       i_hsync;
   logic       i_vde;
   logic [7:0] i_data;
   logic       o_vsync;
   logic       o_hsync;
   logic       o_vde;
   logic [7:0] o_red;
   logic [7:0] o_green;
   logic [7:0] o_blue;

   modport master (
      output i_vsync, i_hsync, i_vde, i_data,
      input  o_vsync, o_hsync, o_vde, o_red, o_green, o_blue
   );

   modport slave (
      input  i_vsync, i_hsync, i_vde, i_data,
      output o_vsync, o_hsync, o_vde, o_red, o_green, o_blue
   );
endinterface

// File: rtl/raw_debayer_2x2.sv
// 2x2 nearest-neighbour Bayer demosaic with one line of storage.
// Fixed two-cycle latency on every output; syncs and vde travel alongside
// the pixel so they stay aligned with the RGB result.
module raw_debayer_2x2 #(
   parameter int unsigned DISPLAY_WIDTH = 640,
   parameter int unsigned COL_WIDTH     = 10,
   parameter int unsigned BAYER_PATTERN = 0
) (
   input  logic             pclk,
   input  logic             reset_n,
   raw_debayer_2x2_if.slave vid
);

   localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(DISPLAY_WIDTH - 1);
   localparam logic [1:0]           PHASE    = 2'(BAYER_PATTERN);

   // ---------------------------------------------------------------------
   // Input-side row/column tracking
   // ---------------------------------------------------------------------
   logic [COL_WIDTH-1:0] col_q, col_d;
   logic                 sat_q, sat_d;         // line ran past the last column
   logic                 parity_q, parity_d;
   logic                 first_row_q, first_row_d;
   logic                 locked_q, locked_d;
   logic                 vde_prev_q;

   logic                 row_clr;
   logic                 vde_fall;
   logic                 store_we;
   logic                 eff_parity;
   logic                 eff_first;
   logic                 eff_locked;

   // Next column/row state and the row flags that apply to this cycle's pixel.
   always_comb begin
      // NOTE: every output of this block is given a default before any branch,
      // so no path leaves a signal unassigned and no latch is inferred.
      row_clr     = !vid.i_vsync;
      vde_fall    = vde_prev_q && !vid.i_vde;
      store_we    = reset_n && vid.i_vde && !sat_q;
      col_d       = col_q;
      sat_d       = sat_q;
      parity_d    = parity_q;
      first_row_d = first_row_q;
      locked_d    = locked_q;

      if (!vid.i_vde) begin
         col_d = '0;
         sat_d = 1'b0;
      end else if (col_q == LAST_COL) begin
         sat_d = 1'b1;
      end else begin
         col_d = col_q + COL_WIDTH'(1);
      end

      // vsync wins over the end-of-line toggle when both land together.
      if (row_clr) begin
         parity_d    = 1'b0;
         first_row_d = 1'b1;
         locked_d    = 1'b1;
      end else if (vde_fall) begin
         parity_d    = !parity_q;
         first_row_d = 1'b0;
      end

      // A pixel coinciding with vsync already belongs to row 0 of the new frame.
      eff_parity = row_clr ? 1'b0 : parity_q;
      eff_first  = row_clr || first_row_q;
      eff_locked = row_clr || locked_q;
   end

   // Row/column state register.
   always_ff @(posedge pclk) begin
      if (!reset_n) begin
         col_q       <= '0;
         sat_q       <= 1'b0;
         parity_q    <= 1'b0;
         first_row_q <= 1'b1;
         locked_q    <= 1'b0;
         vde_prev_q  <= 1'b0;
      end else begin
         col_q       <= col_d;
         sat_q       <= sat_d;
         parity_q    <= parity_d;
         first_row_q <= first_row_d;
         locked_q    <= locked_d;
         vde_prev_q  <= vid.i_vde;
      end
   end

   // ---------------------------------------------------------------------
   // Line store: one row of RAW pixels
   // ---------------------------------------------------------------------
   logic [7:0] line_mem [DISPLAY_WIDTH];
   logic [7:0] up_q;

   // Synchronous line store; the read returns the pixel left by the previous row.
   always_ff @(posedge pclk) begin
      // NOTE: the storage array is deliberately not reset (contents are
      // don't-care until a row has been written). The read and write use
      // non-blocking assignments, so up_q captures the old word at [col]
      // even when that same word is being overwritten this edge.
      if (store_we) begin
         line_mem[col_q] <= vid.i_data;
      end
      up_q <= line_mem[col_q];
   end

   // ---------------------------------------------------------------------
   // Stage 1: 2x2 window and aligned control
   // ---------------------------------------------------------------------
   logic [7:0]           cur_q;
   logic [7:0]           left_q;
   logic [7:0]           upleft_q;
   logic [COL_WIDTH-1:0] s1_col_q;
   logic                 s1_parity_q;
   logic                 s1_first_q;
   logic                 s1_locked_q;
   logic                 s1_vsync_q;
   logic                 s1_hsync_q;
   logic                 s1_vde_q;

   // Shift the window one column and carry the pixel's position and syncs along.
   always_ff @(posedge pclk) begin
      if (!reset_n) begin
         cur_q       <= '0;
         left_q      <= '0;
         upleft_q    <= '0;
         s1_col_q    <= '0;
         s1_parity_q <= 1'b0;
         s1_first_q  <= 1'b1;
         s1_locked_q <= 1'b0;
         s1_vsync_q  <= 1'b1;
         s1_hsync_q  <= 1'b1;
         s1_vde_q    <= 1'b0;
      end else begin
         cur_q       <= vid.i_data;
         left_q      <= cur_q;
         upleft_q    <= up_q;
         s1_col_q    <= col_q;
         s1_parity_q <= eff_parity;
         s1_first_q  <= eff_first;
         s1_locked_q <= eff_locked;
         s1_vsync_q  <= vid.i_vsync;
         s1_hsync_q  <= vid.i_hsync;
         s1_vde_q    <= vid.i_vde;
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2: colour selection
   // ---------------------------------------------------------------------
   logic       er;
   logic       ec;
   logic       pix_ok;
   logic [7:0] green_lu;   // mean of left and up
   logic [7:0] green_cu;   // mean of cur and upleft
   logic [7:0] red_d, green_d, blue_d;

   // Pick R/G/B from the window according to the effective Bayer phase.
   always_comb begin
      er       = s1_parity_q ^ PHASE[1];
      ec       = s1_col_q[0] ^ PHASE[0];
      green_lu = 8'((9'(left_q) + 9'(up_q)) >> 1);
      green_cu = 8'((9'(cur_q) + 9'(upleft_q)) >> 1);
      pix_ok   = s1_vde_q && s1_locked_q && !s1_first_q && (s1_col_q != '0);
      red_d    = '0;
      green_d  = '0;
      blue_d   = '0;

      if (pix_ok) begin
         case ({er, ec})
            2'b00: begin
               red_d   = cur_q;
               green_d = green_lu;
               blue_d  = upleft_q;
            end
            2'b01: begin
               red_d   = left_q;
               green_d = green_cu;
               blue_d  = up_q;
            end
            2'b10: begin
               red_d   = up_q;
               green_d = green_cu;
               blue_d  = left_q;
            end
            default: begin
               red_d   = upleft_q;
               green_d = green_lu;
               blue_d  = cur_q;
            end
         endcase
      end
   end

   logic       o_vsync_q;
   logic       o_hsync_q;
   logic       o_vde_q;
   logic [7:0] o_red_q;
   logic [7:0] o_green_q;
   logic [7:0] o_blue_q;

   // Output register: RGB plus the twice-delayed syncs.
   always_ff @(posedge pclk) begin
      if (!reset_n) begin
         o_vsync_q <= 1'b1;
         o_hsync_q <= 1'b1;
         o_vde_q   <= 1'b0;
         o_red_q   <= '0;
         o_green_q <= '0;
         o_blue_q  <= '0;
      end else begin
         o_vsync_q <= s1_vsync_q;
         o_hsync_q <= s1_hsync_q;
         o_vde_q   <= s1_vde_q;
         o_red_q   <= red_d;
         o_green_q <= green_d;
         o_blue_q  <= blue_d;
      end
   end

   assign vid.o_vsync = o_vsync_q;
   assign vid.o_hsync = o_hsync_q;
   assign vid.o_vde   = o_vde_q;
   assign vid.o_red   = o_red_q;
   assign vid.o_green = o_green_q;
   assign vid.o_blue  = o_blue_q;

endmodule

// File: tb/tb_raw_debayer_2x2.sv
// Bench for raw_debayer_2x2: an RGGB and a BGGR instance share one RAW
// stream; a frame-level model predicts both outputs every cycle, and a few
// hand-worked pixels pin the model itself.
module tb_raw_debayer_2x2;

   localparam int W  = 4;
   localparam int CW = 2;
   localparam logic [26:0] IDLE = {1'b1, 1'b1, 1'b0, 24'h000000};

   logic pclk    = 1'b0;
   logic reset_n = 1'b0;
   logic       drv_vs   = 1'b1;
   logic       drv_hs   = 1'b1;
   logic       drv_vde  = 1'b0;
   logic [7:0] drv_data = 8'h00;

   always #5 pclk = ~pclk;

   raw_debayer_2x2_if bus_a ();
   raw_debayer_2x2_if bus_b ();

   assign bus_a.i_vsync = drv_vs;
   assign bus_a.i_hsync = drv_hs;
   assign bus_a.i_vde   = drv_vde;
   assign bus_a.i_data  = drv_data;
   assign bus_b.i_vsync = drv_vs;
   assign bus_b.i_hsync = drv_hs;
   assign bus_b.i_vde   = drv_vde;
   assign bus_b.i_data  = drv_data;

   raw_debayer_2x2 #(.DISPLAY_WIDTH(W), .COL_WIDTH(CW), .BAYER_PATTERN(0)) dut_rggb (
      .pclk    (pclk),
      .reset_n (reset_n),
      .vid     (bus_a.slave)
   );

   raw_debayer_2x2 #(.DISPLAY_WIDTH(W), .COL_WIDTH(CW), .BAYER_PATTERN(3)) dut_bggr (
      .pclk    (pclk),
      .reset_n (reset_n),
      .vid     (bus_b.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int e_last   = 0;

   // Hand-computed expectations, due on a given cycle.
   int          lit_due  [$];
   bit          lit_inst [$];
   logic [26:0] lit_exp  [$];
   string       lit_name [$];

   task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual={vs,hs,vde,rgb}=%h required=%h", name, cyc, act, exp);
      end
   endtask

   // Demosaic rule for one pixel given its 2x2 neighbourhood.
   function automatic logic [23:0] demosaic(input logic [1:0] bp, input bit par, input bit c0,
                                            input int cur, input int left, input int up,
                                            input int ul);
      int r, g, b;
      bit er, ec;
      er = par ^ bp[1];
      ec = c0 ^ bp[0];
      if (!er && !ec) begin
         r = cur;  g = (left + up) / 2; b = ul;
      end else if (!er && ec) begin
         r = left; g = (cur + ul) / 2;  b = up;
      end else if (er && !ec) begin
         r = up;   g = (cur + ul) / 2;  b = left;
      end else begin
         r = ul;   g = (left + up) / 2; b = cur;
      end
      return {8'(r), 8'(g), 8'(b)};
   endfunction

   // Frame-level reference model plus the per-cycle compare.
   initial begin
      int          m_idx;
      bit          m_par, m_first, m_locked, m_vde_prev;
      logic [7:0]  m_store [W];
      int          m_prev_data, m_prev_read;
      logic [26:0] d1_a, d2_a, d1_b, d2_b;
      int          col, rd;
      bit          e_par, e_first, e_locked, ok;
      logic [23:0] rgb_a, rgb_b;
      logic [26:0] act_a, act_b;

      m_idx = 0; m_par = 0; m_first = 1; m_locked = 0; m_vde_prev = 0;
      m_prev_data = 0; m_prev_read = 0;
      d1_a = IDLE; d2_a = IDLE; d1_b = IDLE; d2_b = IDLE;
      forever begin
         @(posedge pclk);
         cyc++;
         if (!reset_n) begin
            m_idx = 0; m_par = 0; m_first = 1; m_locked = 0; m_vde_prev = 0;
            m_prev_data = 0; m_prev_read = 0;
            d1_a = IDLE; d2_a = IDLE; d1_b = IDLE; d2_b = IDLE;
         end else begin
            d2_a = d1_a;
            d2_b = d1_b;
            col      = (m_idx < W) ? m_idx : W - 1;
            rd       = int'(m_store[col]);
            e_par    = drv_vs ? m_par : 1'b0;
            e_first  = !drv_vs || m_first;
            e_locked = !drv_vs || m_locked;
            ok       = drv_vde && e_locked && !e_first && (col != 0);
            rgb_a = ok ? demosaic(2'd0, e_par, col[0], int'(drv_data), m_prev_data, rd, m_prev_read) : 24'h0;
            rgb_b = ok ? demosaic(2'd3, e_par, col[0], int'(drv_data), m_prev_data, rd, m_prev_read) : 24'h0;
            d1_a = {drv_vs, drv_hs, drv_vde, rgb_a};
            d1_b = {drv_vs, drv_hs, drv_vde, rgb_b};
            if (drv_vde) begin
               if (m_idx < W) m_store[col] = drv_data;
               if (m_idx < W + 1000) m_idx++;
            end else begin
               m_idx = 0;
            end
            if (!drv_vs) begin
               m_par = 0; m_first = 1; m_locked = 1;
            end else if (m_vde_prev && !drv_vde) begin
               m_par = !m_par; m_first = 0;
            end
            m_vde_prev  = drv_vde;
            m_prev_data = int'(drv_data);
            m_prev_read = rd;
         end
         @(negedge pclk);
         act_a = {bus_a.o_vsync, bus_a.o_hsync, bus_a.o_vde, bus_a.o_red, bus_a.o_green, bus_a.o_blue};
         act_b = {bus_b.o_vsync, bus_b.o_hsync, bus_b.o_vde, bus_b.o_red, bus_b.o_green, bus_b.o_blue};
         check("stream_rggb", act_a, d2_a);
         check("stream_bggr", act_b, d2_b);
         while (lit_due.size() > 0 && lit_due[0] <= cyc) begin
            string nm;
            bit    inst;
            logic [26:0] ex;
            void'(lit_due.pop_front());
            inst = lit_inst.pop_front();
            ex   = lit_exp.pop_front();
            nm   = lit_name.pop_front();
            check(nm, inst ? act_b : act_a, ex);
            check({nm, "_model"}, inst ? d2_b : d2_a, ex);
         end
      end
   end

   // One input cycle; e_last records the edge that sampled it.
   task automatic step(input bit vs, input bit hs, input bit vde, input logic [7:0] d);
      drv_vs   = vs;
      drv_hs   = hs;
      drv_vde  = vde;
      drv_data = d;
      @(posedge pclk);
      #1;
      e_last = cyc;
   endtask

   // Horizontal blanking, hsync low on its second cycle, optional vsync on the first.
   task automatic blank(input int n, input bit vs_pulse);
      for (int i = 0; i < n; i++) begin
         step(!(vs_pulse && i == 0), !(i == 1), 1'b0, 8'($urandom));
      end
   endtask

   // Active pixel on the just-driven cycle must come out as (r,g,b).
   task automatic lit(input string name, input bit inst, input logic [7:0] r,
                      input logic [7:0] g, input logic [7:0] b);
      lit_due.push_back(e_last + 1);
      lit_inst.push_back(inst);
      lit_exp.push_back({3'b111, r, g, b});
      lit_name.push_back(name);
   endtask

   initial begin
      logic [7:0] row0 [W];
      logic [7:0] row1 [W];
      logic [7:0] ovr0 [W + 2];
      int nl, n, vs_mid;

      row0 = '{8'd10, 8'd20, 8'd30, 8'd40};
      row1 = '{8'd50, 8'd60, 8'd70, 8'd80};
      ovr0 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};

      // Reset held with active input data.
      reset_n = 1'b0;
      repeat (3) step(1'b1, 1'b1, 1'b1, 8'hFF);
      reset_n = 1'b1;

      // Unlocked: no vsync since reset.
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < W; c++) begin
            step(1'b1, 1'b1, 1'b1, 8'($urandom));
            if (r == 1 && c == 2) lit("unlocked_black", 1'b0, 8'd0, 8'd0, 8'd0);
         end
         blank(3, 1'b0);
      end

      // Directed frame.
      blank(3, 1'b1);
      for (int c = 0; c < W; c++) begin
         step(1'b1, 1'b1, 1'b1, row0[c]);
         if (c == 2) begin
            lit("row0_black_rggb", 1'b0, 8'd0, 8'd0, 8'd0);
            lit("row0_black_bggr", 1'b1, 8'd0, 8'd0, 8'd0);
         end
      end
      blank(3, 1'b0);
      for (int c = 0; c < W; c++) begin
         step(1'b1, 1'b1, 1'b1, row1[c]);
         case (c)
            0: lit("row1_col0_black", 1'b0, 8'd0, 8'd0, 8'd0);
            1: begin
               lit("rggb_r1c1", 1'b0, 8'd10, 8'd35, 8'd60);
               lit("bggr_r1c1", 1'b1, 8'd60, 8'd35, 8'd10);
            end
            2: begin
               lit("rggb_r1c2", 1'b0, 8'd30, 8'd45, 8'd60);
               lit("bggr_r1c2", 1'b1, 8'd60, 8'd45, 8'd30);
            end
            default: begin
               lit("rggb_r1c3", 1'b0, 8'd30, 8'd55, 8'd80);
               lit("bggr_r1c3", 1'b1, 8'd80, 8'd55, 8'd30);
            end
         endcase
      end
      blank(3, 1'b0);

      // Full-scale input: green sum must not wrap.
      blank(3, 1'b1);
      for (int c = 0; c < W; c++) step(1'b1, 1'b1, 1'b1, 8'hFF);
      blank(3, 1'b0);
      for (int c = 0; c < W; c++) begin
         step(1'b1, 1'b1, 1'b1, 8'hFF);
         if (c == 1 || c == 2) begin
            lit("sat_rggb", 1'b0, 8'hFF, 8'hFF, 8'hFF);
            lit("sat_bggr", 1'b1, 8'hFF, 8'hFF, 8'hFF);
         end
      end
      blank(3, 1'b0);

      // Overrun: row of W+2 pixels, next row sees only the first W.
      blank(3, 1'b1);
      for (int c = 0; c < W + 2; c++) step(1'b1, 1'b1, 1'b1, ovr0[c]);
      blank(3, 1'b0);
      for (int c = 0; c < W; c++) begin
         step(1'b1, 1'b1, 1'b1, 8'(100 + 10 * c));
         if (c == 1) lit("ovr_c1", 1'b0, 8'd1, 8'd51, 8'd110);
         if (c == 2) lit("ovr_c2", 1'b0, 8'd3, 8'd61, 8'd110);
         if (c == 3) lit("ovr_c3", 1'b0, 8'd3, 8'd62, 8'd130);
      end
      blank(3, 1'b0);

      // Randomized frames, including vsync during active video and a mid-line reset.
      for (int f = 0; f < 6; f++) begin
         vs_mid = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W)) : -1;
         blank(3, vs_mid < 0);
         nl = int'($urandom_range(3, 5));
         for (int l = 0; l < nl; l++) begin
            n = int'($urandom_range(W, W + 3));
            for (int p = 0; p < n; p++) begin
               if (f == 3 && l == 1 && p == 2) reset_n = 1'b0;
               step(!(l == 0 && p == vs_mid), 1'b1, 1'b1, 8'($urandom));
               reset_n = 1'b1;
            end
            blank(int'($urandom_range(2, 5)), 1'b0);
         end
      end

      blank(4, 1'b0);
      for (int i = 0; i < 10 && lit_due.size() > 0; i++) step(1'b1, 1'b1, 1'b0, 8'h00);
      if (lit_due.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL lit_timeout pending=%0d required=0", lit_due.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
